multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/ctrl_decode.sv | 42 ++++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle controller: FSM states,
// opcode classes, ALUOP encodings and the opcode constants used by decode.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_D    = 3'd1,
    CLS_R    = 3'd2,
    CLS_CB   = 3'd3,
    CLS_B    = 3'd4
  } op_class_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address add for loads/stores
  localparam logic [1:0] ALUOP_PASSB = 2'b01;  // pass B, zero test for CB
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // ALU decodes the funct field

  // Fully specified 11-bit opcodes
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;

  // Prefix-matched opcodes (low bits belong to the immediate)
  localparam logic [7:0] OP_CBZ_PFX  = 8'b10110100;  // OPCode[10:3]
  localparam logic [7:0] OP_CBNZ_PFX = 8'b10110101;  // OPCode[10:3]
  localparam logic [5:0] OP_B_PFX    = 6'b000101;    // OPCode[10:5]

  // Everything the FSM needs to remember about the instruction after DECODE
  typedef struct packed {
    op_class_e cls;
    logic      is_store;  // STUR within the D class
    logic      is_cbnz;   // branch sense inverted within the CB class
    logic      reg2loc;   // STUR / CBZ / CBNZ read Rt through port 2
  } dec_t;

  localparam dec_t DEC_NONE = '{cls: CLS_NONE, is_store: 1'b0,
                                is_cbnz: 1'b0, reg2loc: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: OPCode -> instruction class and an
// illegal flag. CBNZ is legal only when CTRL_CBNZ_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [10:0] i_opcode,
  output dec_t        o_dec,
  output logic        o_illegal
);

  // Classify the opcode; anything not recognised is flagged illegal
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_dec     = DEC_NONE;
    o_illegal = 1'b0;
    if (i_opcode == OP_LDUR) begin
      o_dec.cls = CLS_D;
    end else if (i_opcode == OP_STUR) begin
      o_dec.cls      = CLS_D;
      o_dec.is_store = 1'b1;
      o_dec.reg2loc  = 1'b1;
    end else if (i_opcode[10:3] == OP_CBZ_PFX) begin
      o_dec.cls     = CLS_CB;
      o_dec.reg2loc = 1'b1;
`ifdef CTRL_CBNZ_EN
    end else if (i_opcode[10:3] == OP_CBNZ_PFX) begin
      o_dec.cls     = CLS_CB;
      o_dec.reg2loc = 1'b1;
      o_dec.is_cbnz = 1'b1;
`endif
    end else if (i_opcode[10:5] == OP_B_PFX) begin
      o_dec.cls = CLS_B;
    end else if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
                 i_opcode == OP_AND || i_opcode == OP_ORR ||
                 i_opcode == OP_LSL || i_opcode == OP_LSR) begin
      o_dec.cls = CLS_R;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB plus a sticky
// FAULT state for illegal opcodes and memory timeouts. Counts retired
// instructions on every PCWrite pulse. Build option CTRL_CBNZ_EN adds CBNZ.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,  // max MemReady wait cycles, 1..255
  parameter int CNT_W       = 32   // retired-instruction counter width
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      OPCode,
  input  logic             MemReady,
  input  logic             Zero,
  output logic             IMemRead,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOP,
  output logic             Fault,
  output logic [CNT_W-1:0] Retired,
  output logic [2:0]       State
);
  import ctrl_pkg::*;

  // Wait count at which one more idle MemReady cycle means timeout
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  dec_t             r_dec;
  dec_t             w_dec;
  logic             w_illegal;
  logic [7:0]       r_wait;
  logic             w_wait_last;
  logic [CNT_W-1:0] r_retired;

  ctrl_decode u_decode (
    .i_opcode  (OPCode),
    .o_dec     (w_dec),
    .o_illegal (w_illegal)
  );

  assign w_wait_last = (r_wait == WAIT_LAST);

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; MemReady wins over a timeout in the same cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (MemReady)         w_next = S_DECODE;
        else if (w_wait_last) w_next = S_FAULT;
      end
      S_DECODE: w_next = w_illegal ? S_FAULT : S_EXEC;
      S_EXEC: begin
        case (r_dec.cls)
          CLS_D:         w_next = S_MEM;
          CLS_R:         w_next = S_WB;
          CLS_CB, CLS_B: w_next = S_FETCH;
          default:       w_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (MemReady)         w_next = r_dec.is_store ? S_FETCH : S_WB;
        else if (w_wait_last) w_next = S_FAULT;
      end
      S_WB:    w_next = S_FETCH;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  // Output decode: everything defaults to 0 and is raised per state
  always_comb begin
    IMemRead = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOP    = ALUOP_ADD;
    Fault    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        IMemRead = 1'b1;
        IRWrite  = MemReady;
      end
      // Class is not registered yet, so Reg2Loc comes straight from decode
      S_DECODE: Reg2Loc = w_dec.reg2loc;
      S_EXEC: begin
        Reg2Loc = r_dec.reg2loc;
        case (r_dec.cls)
          CLS_D: begin
            ALUSrc = 1'b1;
            ALUOP  = ALUOP_ADD;
          end
          CLS_R: ALUOP = ALUOP_RTYPE;
          CLS_CB: begin
            ALUOP   = ALUOP_PASSB;
            Branch  = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = r_dec.is_cbnz ? ~Zero : Zero;
          end
          CLS_B: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        Reg2Loc  = r_dec.reg2loc;
        MemRead  = ~r_dec.is_store;
        MemWrite = r_dec.is_store;
        PCWrite  = r_dec.is_store & MemReady;
      end
      S_WB: begin
        Reg2Loc  = r_dec.reg2loc;
        RegWrite = 1'b1;
        MemToReg = (r_dec.cls == CLS_D);
        PCWrite  = 1'b1;
      end
      S_FAULT: Fault = 1'b1;
      default: ;
    endcase
  end

  // Latch the instruction class while in DECODE
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                   r_dec <= DEC_NONE;
    else if (r_state == S_DECODE) r_dec <= w_dec;
  end

  // Memory wait counter: cleared on any state change, counts idle cycles
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wait <= '0;
    end else if (w_next != r_state) begin
      r_wait <= '0;
    end else if (!MemReady && (r_state == S_FETCH || r_state == S_MEM)) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  // Retired counter advances with each PCWrite pulse and wraps naturally
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)        r_retired <= '0;
    else if (PCWrite) r_retired <= r_retired + 1'b1;
  end

  assign Retired = r_retired;
  assign State   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control, built with
// MEM_TIMEOUT=4 and CNT_W=4 so timeout and counter wrap are reachable.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  // Expected control-vector bits
  localparam logic [13:0] C_IMR  = 14'h2000;
  localparam logic [13:0] C_IRW  = 14'h1000;
  localparam logic [13:0] C_PCW  = 14'h0800;
  localparam logic [13:0] C_PCS  = 14'h0400;
  localparam logic [13:0] C_R2L  = 14'h0200;
  localparam logic [13:0] C_ALS  = 14'h0100;
  localparam logic [13:0] C_M2R  = 14'h0080;
  localparam logic [13:0] C_RGW  = 14'h0040;
  localparam logic [13:0] C_MRD  = 14'h0020;
  localparam logic [13:0] C_MWR  = 14'h0010;
  localparam logic [13:0] C_BR   = 14'h0008;
  localparam logic [13:0] C_AOP2 = 14'h0004;  // ALUOP = 10
  localparam logic [13:0] C_AOP1 = 14'h0002;  // ALUOP = 01
  localparam logic [13:0] C_FLT  = 14'h0001;
  localparam logic [13:0] C_FET  = C_IMR | C_IRW;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100101;
  localparam logic [10:0] T_CBNZ = 11'b10110101000;
  localparam logic [10:0] T_B    = 11'b00010110011;

  logic          CLK = 1'b0;
  logic          Reset, MemReady, Zero;
  logic [10:0]   OPCode;
  logic          IMemRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
  logic          MemToReg, RegWrite, MemRead, MemWrite, Branch, Fault;
  logic [1:0]    ALUOP;
  logic [CW-1:0] Retired;
  logic [2:0]    State;
  logic [13:0]   w_ctl;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .OPCode(OPCode), .MemReady(MemReady),
    .Zero(Zero), .IMemRead(IMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOP(ALUOP), .Fault(Fault), .Retired(Retired),
    .State(State)
  );

  assign w_ctl = {IMemRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc,
                  MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP, Fault};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check state and controls, advance
  task automatic cyc(input string tag, input logic [2:0] st,
                     input logic [13:0] ce, input logic mr, input logic z);
    MemReady = mr;
    Zero     = z;
    #1;
    check({tag, " state"}, 32'(State), 32'(st));
    check({tag, " ctl"}, 32'(w_ctl), 32'(ce));
    @(posedge CLK);
    #1;
  endtask

  task automatic run_b(input string tag);
    OPCode = T_B;
    cyc({tag, " f"}, S_FETCH,  C_FET,         1'b1, 1'b0);
    cyc({tag, " d"}, S_DECODE, '0,            1'b1, 1'b0);
    cyc({tag, " e"}, S_EXEC,   C_PCW | C_PCS, 1'b1, 1'b0);
    exp_ret = (exp_ret + 1) % (1 << CW);
  endtask

  // Release reset just after an edge so the next full cycle is the first
  task automatic release_reset();
    @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  logic [10:0] r_ops [5] = '{11'b11001011000, 11'b10001010000,
                             11'b10101010000, 11'b11010011011,
                             11'b11010011010};

  initial begin
    Reset = 1'b1; MemReady = 1'b0; Zero = 1'b0; OPCode = '0;
    #1;
    check("rst state", 32'(State), 32'(S_FETCH));
    check("rst fault", 32'(Fault), 32'd0);
    check("rst retired", 32'(Retired), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;

    // ADD, zero wait: 4 cycles, RegWrite only in WB
    OPCode = T_ADD;
    cyc("add f", S_FETCH,  C_FET,          1'b1, 1'b0);
    cyc("add d", S_DECODE, '0,             1'b1, 1'b0);
    cyc("add e", S_EXEC,   C_AOP2,         1'b1, 1'b0);
    cyc("add w", S_WB,     C_RGW | C_PCW,  1'b1, 1'b0);
    exp_ret = 1;
    check("add retired", 32'(Retired), 32'(exp_ret));
    check("add back to fetch", 32'(State), 32'(S_FETCH));

    // LDUR with three MEM wait cycles: 8 cycles total
    OPCode = T_LDUR;
    cyc("ldur f", S_FETCH,  C_FET,          1'b1, 1'b0);
    cyc("ldur d", S_DECODE, '0,             1'b1, 1'b0);
    cyc("ldur e", S_EXEC,   C_ALS,          1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("ldur mwait", S_MEM, C_MRD,       1'b0, 1'b0);
    cyc("ldur m",  S_MEM,   C_MRD,                  1'b1, 1'b0);
    cyc("ldur w",  S_WB,    C_RGW | C_M2R | C_PCW,  1'b1, 1'b0);
    exp_ret = 2;
    check("ldur retired", 32'(Retired), 32'(exp_ret));

    // STUR, zero wait: 4 cycles, Reg2Loc from DECODE on
    OPCode = T_STUR;
    cyc("stur f", S_FETCH,  C_FET,                  1'b1, 1'b0);
    cyc("stur d", S_DECODE, C_R2L,                  1'b1, 1'b0);
    cyc("stur e", S_EXEC,   C_R2L | C_ALS,          1'b1, 1'b0);
    cyc("stur m", S_MEM,    C_R2L | C_MWR | C_PCW,  1'b1, 1'b0);
    exp_ret = 3;
    check("stur retired", 32'(Retired), 32'(exp_ret));

    // CBZ taken and not taken
    OPCode = T_CBZ;
    cyc("cbz1 f", S_FETCH,  C_FET, 1'b1, 1'b1);
    cyc("cbz1 d", S_DECODE, C_R2L, 1'b1, 1'b1);
    cyc("cbz1 e", S_EXEC,   C_R2L | C_BR | C_AOP1 | C_PCW | C_PCS, 1'b1, 1'b1);
    cyc("cbz0 f", S_FETCH,  C_FET, 1'b1, 1'b0);
    cyc("cbz0 d", S_DECODE, C_R2L, 1'b1, 1'b0);
    cyc("cbz0 e", S_EXEC,   C_R2L | C_BR | C_AOP1 | C_PCW, 1'b1, 1'b0);
    exp_ret = 5;
    check("cbz retired", 32'(Retired), 32'(exp_ret));

    // Remaining R-type opcodes
    for (int i = 0; i < 5; i++) begin
      OPCode = r_ops[i];
      cyc("rt f", S_FETCH,  C_FET,         1'b1, 1'b0);
      cyc("rt d", S_DECODE, '0,            1'b1, 1'b0);
      cyc("rt e", S_EXEC,   C_AOP2,        1'b1, 1'b0);
      cyc("rt w", S_WB,     C_RGW | C_PCW, 1'b1, 1'b0);
    end
    exp_ret = 10;
    check("rtype retired", 32'(Retired), 32'(exp_ret));

    run_b("b");
    check("b retired", 32'(Retired), 32'(exp_ret));

    // FETCH waits 3 cycles, MemReady on the 4th (the limit) wins
    OPCode = T_B;
    for (int i = 0; i < 3; i++)
      cyc("fwait", S_FETCH, C_IMR, 1'b0, 1'b0);
    cyc("fwait rdy", S_FETCH,  C_FET,         1'b1, 1'b0);
    cyc("fwait d",   S_DECODE, '0,            1'b1, 1'b0);
    cyc("fwait e",   S_EXEC,   C_PCW | C_PCS, 1'b1, 1'b0);
    exp_ret = 12;
    check("fwait retired", 32'(Retired), 32'(exp_ret));

    // CBNZ: legal only with the build option
    OPCode = T_CBNZ;
    cyc("cbnz f", S_FETCH, C_FET, 1'b1, 1'b0);
`ifdef CTRL_CBNZ_EN
    cyc("cbnz d", S_DECODE, C_R2L, 1'b1, 1'b0);
    cyc("cbnz e", S_EXEC,   C_R2L | C_BR | C_AOP1 | C_PCW | C_PCS, 1'b1, 1'b0);
    exp_ret = 13;
    check("cbnz retired", 32'(Retired), 32'(exp_ret));
`else
    cyc("cbnz d",   S_DECODE, '0,    1'b1, 1'b0);
    cyc("cbnz flt", S_FAULT,  C_FLT, 1'b1, 1'b0);
    check("cbnz retired", 32'(Retired), 32'(exp_ret));
    Reset = 1'b1;
    #1;
    exp_ret = 0;
    release_reset();
`endif

    // Illegal opcode 0 -> sticky FAULT, cleared only by reset
    OPCode = 11'b00000000000;
    cyc("ill f",    S_FETCH,  C_FET, 1'b1, 1'b0);
    cyc("ill d",    S_DECODE, '0,    1'b1, 1'b0);
    cyc("ill flt1", S_FAULT,  C_FLT, 1'b1, 1'b1);
    cyc("ill flt2", S_FAULT,  C_FLT, 1'b0, 1'b0);
    check("ill retired", 32'(Retired), 32'(exp_ret));
    Reset = 1'b1;
    #1;
    exp_ret = 0;
    check("ill rst state", 32'(State), 32'(S_FETCH));
    check("ill rst fault", 32'(Fault), 32'd0);
    check("ill rst retired", 32'(Retired), 32'd0);
    release_reset();

    // Reset during STUR MEM aborts with no PCWrite
    OPCode = T_STUR;
    cyc("sturr f", S_FETCH,  C_FET,         1'b1, 1'b0);
    cyc("sturr d", S_DECODE, C_R2L,         1'b1, 1'b0);
    cyc("sturr e", S_EXEC,   C_R2L | C_ALS, 1'b1, 1'b0);
    MemReady = 1'b0;
    #1;
    check("sturr memwrite", 32'(MemWrite), 32'd1);
    Reset = 1'b1;
    #1;
    check("sturr rst memwrite", 32'(MemWrite), 32'd0);
    check("sturr rst pcwrite", 32'(PCWrite), 32'd0);
    check("sturr rst state", 32'(State), 32'(S_FETCH));
    check("sturr rst retired", 32'(Retired), 32'(exp_ret));
    release_reset();

    // FETCH timeout: four idle cycles -> FAULT
    for (int i = 0; i < TO; i++)
      cyc("tmo fetch", S_FETCH, C_IMR, 1'b0, 1'b0);
    cyc("tmo flt1", S_FAULT, C_FLT, 1'b1, 1'b0);
    cyc("tmo flt2", S_FAULT, C_FLT, 1'b1, 1'b0);
    Reset = 1'b1;
    #1;
    check("tmo rst fault", 32'(Fault), 32'd0);
    release_reset();

    // 16 branches wrap the 4-bit retired counter back to 0
    exp_ret = 0;
    for (int i = 0; i < 15; i++) run_b("wrap");
    check("wrap 15", 32'(Retired), 32'(exp_ret));
    check("wrap 15 const", 32'(Retired), 32'd15);
    run_b("wrap");
    check("wrap 16", 32'(Retired), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
